// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. Arbitration is
//   round-robin, and one operation is in flight at a time. The winning request
//   is registered onto the ALU inputs. The ALU result is captured one cycle
//   later and returned on a per-requester response channel that supports
//   backpressure.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   reqN_valid/ready          request handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op   request operands and opcode
//   rspN_valid/ready          response handshake for requester N
//   rsp_c, rsp_zero           result and zero flag shared by both responses
//   alu_a, alu_b, alu_op      registered drive to the external ALU
//   alu_c, alu_zero           external ALU result and zero flag
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic grant0, grant1;
  logic owner_rsp_ready;

  // On a tie the requester that was not granted last wins. A withdrawn valid
  // leaves last_grant untouched because no transition to EXEC is taken.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
  end

  always_comb begin
    req0_ready = (state_q == ST_IDLE) && !rst && grant0;
    req1_ready = (state_q == ST_IDLE) && !rst && grant1;
    rsp0_valid = (state_q == ST_RESP) && !owner_q;
    rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  end

  always_comb begin
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_c_d      = rsp_c_q;
    rsp_zero_d   = rsp_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          state_d      = ST_EXEC;
          owner_d      = grant1;
          last_grant_d = grant1;
          alu_a_d      = grant1 ? req1_a  : req0_a;
          alu_b_d      = grant1 ? req1_b  : req0_b;
          alu_op_d     = grant1 ? req1_op : req0_op;
        end
      end
      ST_EXEC: begin
        state_d    = ST_RESP;
        rsp_c_d    = alu_c;
        rsp_zero_d = alu_zero;
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_c_q      <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_c_q      <= rsp_c_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_c    = rsp_c_q;
  assign rsp_zero = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_c;
  logic        rsp_zero;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;
  logic        alu_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ALU stub: op 1 add, op 2 subtract.
  always_comb begin
    case (alu_op)
      4'h1:    alu_c = alu_a + alu_b;
      4'h2:    alu_c = alu_a - alu_b;
      default: alu_c = 32'h0;
    endcase
    alu_zero = (alu_c == 32'h0);
  end

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_c(rsp_c), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero)
  );

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    req0_valid = 1; req1_valid = 1;
    #12;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
    total++; if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0) begin bad++; $display("FAIL reset_alu: got %0h %0h %0h want 0 0 0", alu_a, alu_b, alu_op); end
    total++; if (rsp_c !== 0 || rsp_zero !== 1'b0) begin bad++; $display("FAIL reset_rsp: got %0h %b want 0 0", rsp_c, rsp_zero); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
    @(negedge clk);
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1; req0_a = 10; req0_b = 5; req0_op = 4'h1; rsp0_ready = 1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    total++; if (alu_a !== 10 || alu_b !== 5 || alu_op !== 4'h1) begin bad++; $display("FAIL single_alu: got %0d %0d %0h want 10 5 1", alu_a, alu_b, alu_op); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_exec_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_valid: got %b%b want 10", rsp0_valid, rsp1_valid); end
    total++; if (rsp_c !== 15 || rsp_zero !== 1'b0) begin bad++; $display("FAIL single_rsp_c: got %0d %b want 15 0", rsp_c, rsp_zero); end
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_done: got %b%b want 00", rsp0_valid, rsp1_valid); end
    rsp0_ready = 0;
  endtask

  task automatic test_tie();
    apply_reset();
    req0_valid = 1; req0_a = 7; req0_b = 7; req0_op = 4'h2;
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 4'h1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL tie_first_grant: got %b%b want 10", req0_ready, req1_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    #1;
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL tie_exec_ready: got %b want 0", req1_ready); end
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1 || rsp_c !== 0 || rsp_zero !== 1'b1) begin bad++; $display("FAIL tie_rsp0: got v=%b c=%0d z=%b want 1 0 1", rsp0_valid, rsp_c, rsp_zero); end
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL tie_second_grant: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    total++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_c !== 7 || rsp_zero !== 1'b0) begin bad++; $display("FAIL tie_rsp1: got v=%b%b c=%0d z=%b want 01 7 0", rsp0_valid, rsp1_valid, rsp_c, rsp_zero); end
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;
  endtask

  task automatic test_contention();
    logic [31:0] a0 [4] = '{32'd1, 32'd100, 32'd5, 32'hFFFFFFFF};
    logic [31:0] b0 [4] = '{32'd2, 32'd1,   32'd5, 32'd1};
    logic [3:0]  o0 [4] = '{4'h1, 4'h2, 4'h2, 4'h1};
    logic [31:0] e0 [4] = '{32'd3, 32'd99, 32'd0, 32'd0};
    logic [31:0] a1 [4] = '{32'd20, 32'd9, 32'd7, 32'd0};
    logic [31:0] b1 [4] = '{32'd22, 32'd4, 32'd0, 32'd1};
    logic [3:0]  o1 [4] = '{4'h1, 4'h2, 4'h1, 4'h2};
    logic [31:0] e1 [4] = '{32'd42, 32'd5, 32'd7, 32'hFFFFFFFF};
    int i0 = 0;
    int i1 = 0;
    int g;
    bit got;
    logic [31:0] exp_c;
    apply_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    for (int s = 0; s < 8; s++) begin
      if (s != 0) @(negedge clk);
      req0_valid = (i0 < 4); if (i0 < 4) begin req0_a = a0[i0]; req0_b = b0[i0]; req0_op = o0[i0]; end
      req1_valid = (i1 < 4); if (i1 < 4) begin req1_a = a1[i1]; req1_b = b1[i1]; req1_op = o1[i1]; end
      #1;
      g = -1;
      if (req0_ready && !req1_ready) g = 0;
      else if (req1_ready && !req0_ready) g = 1;
      total++; if (g != s % 2) begin bad++; $display("FAIL contention_grant[%0d]: got %0d want %0d", s, g, s % 2); end
      if (g < 0) begin
        @(posedge clk);
        continue;
      end
      @(posedge clk);
      if (g == 0) begin exp_c = e0[i0]; i0++; end
      else        begin exp_c = e1[i1]; i1++; end
      @(negedge clk);
      req0_valid = (i0 < 4); if (i0 < 4) begin req0_a = a0[i0]; req0_b = b0[i0]; req0_op = o0[i0]; end
      req1_valid = (i1 < 4); if (i1 < 4) begin req1_a = a1[i1]; req1_b = b1[i1]; req1_op = o1[i1]; end
      got = 0;
      for (int w = 0; w < 4 && !got; w++) begin
        if ((g == 0) ? rsp0_valid : rsp1_valid) got = 1;
        else @(negedge clk);
      end
      total++;
      if (!got) begin bad++; $display("FAIL contention_timeout[%0d]: got no rsp want rsp%0d", s, g); end
      else if (rsp_c !== exp_c) begin bad++; $display("FAIL contention_rsp_c[%0d]: got %0h want %0h", s, rsp_c, exp_c); end
      @(posedge clk);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    req1_valid = 1; req1_a = 50; req1_b = 8; req1_op = 4'h2;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL bp_req1_ready: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_a = 2; req0_b = 3; req0_op = 4'h1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      total++; if (rsp1_valid !== 1'b1 || rsp_c !== 42 || req0_ready !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d]: got v=%b c=%0d rdy0=%b want 1 42 0", c, rsp1_valid, rsp_c, req0_ready); end
    end
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;
    #1;
    total++; if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL bp_after: got rdy0=%b v1=%b want 1 0", req0_ready, rsp1_valid); end
    rsp0_ready = 1;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1 || rsp_c !== 5) begin bad++; $display("FAIL bp_req0_rsp: got v=%b c=%0d want 1 5", rsp0_valid, rsp_c); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid_exec();
    int pulses = 0;
    apply_reset();
    rsp0_ready = 1;
    req0_valid = 1; req0_a = 9; req0_b = 6; req0_op = 4'h1;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    total++; if (rsp_c !== 15) begin bad++; $display("FAIL mid_setup_c: got %0d want 15", rsp_c); end
    @(negedge clk);
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 4'h2;
    @(negedge clk);
    req0_valid = 0;
    total++; if (alu_a !== 1 || alu_op !== 4'h2) begin bad++; $display("FAIL mid_exec_alu: got %0d %0h want 1 2", alu_a, alu_op); end
    #2;
    rst = 1;
    #1;
    total++; if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0 || rsp_c !== 0 || rsp_zero !== 1'b0) begin bad++; $display("FAIL mid_reset_regs: got %0h %0h %0h %0h %b want zeros", alu_a, alu_b, alu_op, rsp_c, rsp_zero); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || req0_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_hs: got %b%b%b want 000", rsp0_valid, rsp1_valid, req0_ready); end
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      if (rsp0_valid || rsp1_valid) pulses++;
      @(negedge clk);
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_rsp: got %0d pulses want 0", pulses); end
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 4'h1; rsp1_ready = 1;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL mid_next_ready: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    total++; if (rsp1_valid !== 1'b1 || rsp_c !== 7) begin bad++; $display("FAIL mid_next_rsp: got v=%b c=%0d want 1 7", rsp1_valid, rsp_c); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_withdrawn();
    apply_reset();
    req0_valid = 1; req0_a = 8; req0_b = 2; req0_op = 4'h2;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1 || rsp_c !== 6) begin bad++; $display("FAIL wd_rsp0: got v=%b c=%0d want 1 6", rsp0_valid, rsp_c); end
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 4'h1;
    #1;
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL wd_req1_ready: got %b want 0", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL wd_idle: got %b%b want 00", rsp0_valid, rsp1_valid); end
    req0_valid = 1; req1_valid = 1;
    #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL wd_last_grant: got %b%b want 01", req0_ready, req1_ready); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_withdrawn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
